// File: rtl/serial_twos_receiver_pkg.sv
// Shared types and sizing helpers for the serial two's complement receiver.
package serial_twos_receiver_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Counter must hold values 0..width inclusive.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_twos_receiver_negate_cell.sv
// Bit-serial invert-plus-carry negation cell; carry flop presets to 1 at frame start.
module serial_negate_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic preset,
    input  logic en,
    input  logic neg,
    input  logic b,
    output logic r
);

    logic r_carry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_carry <= 1'b1;
        end else if (preset) begin
            r_carry <= 1'b1;
        end else if (en && neg) begin
            r_carry <= ~b & r_carry;
        end
    end

    assign r = neg ? (~b ^ r_carry) : b;

endmodule

// File: rtl/serial_twos_receiver.sv
// LSB-first serial receiver with optional on-the-fly negation and a valid/ready
// parallel output; flags the unnegatable most-negative input via ovf.
module serial_twos_receiver
    import serial_twos_receiver_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             neg,
    input  logic             sin,
    input  logic             sin_valid,
    output logic             busy,
    output logic [WIDTH-1:0] out_word,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             ovf
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next;
    logic             r_neg;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sreg;
    logic             r_valid;
    logic             r_busy;
    logic             r_ovf;

    logic             w_accept_start;
    logic             w_shift;
    logic             w_last;
    logic             w_bit_r;

    always_comb begin
        w_next         = r_state;
        w_accept_start = 1'b0;
        w_shift        = 1'b0;
        w_last         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept_start = 1'b1;
                    w_next         = SHIFT;
                end
            end
            SHIFT: begin
                w_shift = sin_valid;
                w_last  = sin_valid && (r_cnt == LAST_CNT);
                if (w_last) begin
                    w_next = HOLD;
                end
            end
            HOLD: begin
                // Handshake cycle doubles as the start slot for a back-to-back frame.
                if (out_ready) begin
                    if (start) begin
                        w_accept_start = 1'b1;
                        w_next         = SHIFT;
                    end else begin
                        w_next = IDLE;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
    end

    serial_negate_cell u_negate_cell (
        .clk    (clk),
        .rst_n  (rst_n),
        .preset (w_accept_start),
        .en     (w_shift),
        .neg    (r_neg),
        .b      (sin),
        .r      (w_bit_r)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_neg   <= 1'b0;
            r_cnt   <= '0;
            r_sreg  <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next == SHIFT);
            r_valid <= (w_next == HOLD);
            if (w_accept_start) begin
                r_neg  <= neg;
                r_cnt  <= '0;
                r_sreg <= '0;
                r_ovf  <= 1'b0;
            end else if (w_shift) begin
                r_sreg <= {w_bit_r, r_sreg[WIDTH-1:1]};
                r_cnt  <= r_cnt + CW'(1);
                if (w_last) begin
                    r_ovf <= r_neg & sin & w_bit_r;
                end
            end
        end
    end

    assign busy      = r_busy;
    assign out_word  = r_sreg;
    assign out_valid = r_valid;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_serial_twos_receiver.sv
// Directed scoreboard bench for serial_twos_receiver at WIDTH=4.
module tb_serial_twos_receiver;

    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] word;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         neg = 1'b0;
    logic         sin = 1'b0;
    logic         sin_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic         busy;
    logic         out_valid;
    logic         ovf;
    logic [W-1:0] out_word;

    exp_t sbq[$];
    exp_t last_exp;
    int   n_checks = 0;
    int   n_pass = 0;
    int   cyc = 0;
    int   t_start = 0;

    serial_twos_receiver #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .neg       (neg),
        .sin       (sin),
        .sin_valid (sin_valid),
        .busy      (busy),
        .out_word  (out_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic exp_t model(input logic n, input logic [W-1:0] x);
        exp_t e;
        logic [W-1:0] msb_only;
        msb_only = '0;
        msb_only[W-1] = 1'b1;
        e.word = n ? W'(~x + 1'b1) : x;
        e.ovf  = n && (x == msb_only);
        return e;
    endfunction

    task automatic begin_frame(input logic n, input logic [W-1:0] x);
        sbq.push_back(model(n, x));
        start   = 1'b1;
        neg     = n;
        t_start = cyc;
        @(negedge clk);
        start = 1'b0;
        neg   = 1'($urandom);
    endtask

    task automatic send_bits(input logic [W-1:0] x, input logic [W-1:0] stall_mask,
                             input bit check_busy);
        for (int i = 0; i < W; i++) begin
            if (stall_mask[i]) begin
                sin_valid = 1'b0;
                sin       = 1'($urandom);
                @(negedge clk);
            end
            sin_valid = 1'b1;
            sin       = x[i];
            if (check_busy) chk("busy_in_shift", 32'(busy), 32'd1);
            @(negedge clk);
        end
        sin_valid = 1'b0;
        sin       = 1'($urandom);
    endtask

    task automatic wait_result(input string tag, input int exp_lat);
        int waited;
        waited = 0;
        while (!out_valid && waited < 30) begin
            @(negedge clk);
            waited++;
        end
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        if (out_valid) begin
            chk({tag, "_latency"}, 32'(cyc - t_start), 32'(exp_lat));
            if (sbq.size() == 0) begin
                chk({tag, "_sb_empty"}, 32'd0, 32'd1);
            end else begin
                last_exp = sbq.pop_front();
                chk({tag, "_word"}, 32'(out_word), 32'(last_exp.word));
                chk({tag, "_ovf"}, 32'(ovf), 32'(last_exp.ovf));
            end
        end
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_word", 32'(out_word), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: negate 0011 -> 1101
        begin_frame(1'b1, 4'b0011);
        send_bits(4'b0011, 4'b0000, 1'b0);
        wait_result("s1", 5);
        handshake("s1");

        // 2: pass-through 1010, busy only during bit cycles
        begin_frame(1'b0, 4'b1010);
        send_bits(4'b1010, 4'b0000, 1'b1);
        chk("s2_busy_low_in_hold", 32'(busy), 32'd0);
        wait_result("s2", 5);
        handshake("s2");

        // 3: most-negative and zero
        begin_frame(1'b1, 4'b1000);
        send_bits(4'b1000, 4'b0000, 1'b0);
        wait_result("s3a", 5);
        handshake("s3a");
        begin_frame(1'b1, 4'b0000);
        send_bits(4'b0000, 4'b0000, 1'b0);
        wait_result("s3b", 5);
        handshake("s3b");

        // 4: two stall cycles stretch latency by two
        begin_frame(1'b1, 4'b0110);
        send_bits(4'b0110, 4'b0110, 1'b1);
        wait_result("s4", 7);
        handshake("s4");

        // 5: hold with ready low (start ignored), then back-to-back frame
        begin_frame(1'b1, 4'b1000);
        send_bits(4'b1000, 4'b0000, 1'b0);
        wait_result("s5a", 5);
        for (int k = 0; k < 3; k++) begin
            start = 1'b1;
            neg   = 1'b1;
            @(negedge clk);
            chk("s5_hold_valid", 32'(out_valid), 32'd1);
            chk("s5_hold_word", 32'(out_word), 32'(last_exp.word));
            chk("s5_hold_ovf", 32'(ovf), 32'(last_exp.ovf));
            chk("s5_hold_busy", 32'(busy), 32'd0);
        end
        out_ready = 1'b1;
        start     = 1'b1;
        neg       = 1'b0;
        sbq.push_back(model(1'b0, 4'b0101));
        t_start = cyc;
        @(negedge clk);
        out_ready = 1'b0;
        start     = 1'b0;
        chk("s5_b2b_valid_drop", 32'(out_valid), 32'd0);
        chk("s5_b2b_busy", 32'(busy), 32'd1);
        send_bits(4'b0101, 4'b0000, 1'b1);
        wait_result("s5b", 5);
        handshake("s5b");

        // 6: async reset mid-frame discards the partial word
        begin_frame(1'b1, 4'b0110);
        sin_valid = 1'b1;
        sin       = 1'b0;
        @(negedge clk);
        sin = 1'b1;
        @(negedge clk);
        sin_valid = 1'b0;
        chk("s6_partial_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("s6_rst_valid", 32'(out_valid), 32'd0);
        chk("s6_rst_busy", 32'(busy), 32'd0);
        chk("s6_rst_word", 32'(out_word), 32'd0);
        chk("s6_rst_ovf", 32'(ovf), 32'd0);
        void'(sbq.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        begin_frame(1'b1, 4'b0001);
        send_bits(4'b0001, 4'b0000, 1'b0);
        wait_result("s6", 5);
        handshake("s6");

        chk("sb_drained", 32'(sbq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
